// File: rtl/udp_rx_vid_unpack.sv
// udp_rx_vid_unpack: hunts for a 32-bit frame head in the app_rx byte stream,
// then packs payload bytes MSB-first into PIX_BYTES-wide pixels with
// frame-start, line-end, frame-done and frame-error markers.
module udp_rx_vid_unpack #(
    parameter logic [31:0] FRAME_HEAD = 32'hF3ED7A93,
    parameter int unsigned PIX_BYTES  = 2,
    parameter int unsigned LINE_PIX   = 1024,
    parameter int unsigned TIMEOUT    = 4096,
    parameter bit          RESYNC     = 1'b1
) (
    input  logic                   app_rx_clk,
    input  logic                   rstn,
    input  logic                   app_rx_data_valid,
    input  logic [7:0]             app_rx_data,
    input  logic [24:0]            app_rx_data_total,
    output logic                   vid_clk,
    output logic                   vid_vs,
    output logic                   vid_de,
    output logic [8*PIX_BYTES-1:0] vid_data,
    output logic                   vid_hs,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt
);

    localparam int unsigned PW = 8 * PIX_BYTES;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic {
        HUNT,
        PAYLOAD
    } state_t;

    state_t         state, state_nxt;
    logic [31:0]    hd, hd_nxt, hd_shift;
    logic [24:0]    tot, tot_nxt;
    logic [24:0]    byte_cnt, byte_cnt_nxt;
    logic [1:0]     lane, lane_nxt;
    logic [15:0]    pix_cnt, pix_cnt_nxt;
    logic [TW-1:0]  idle_cnt, idle_nxt;
    logic [PW-1:0]  pix, pix_nxt, pix_shift;
    logic [PW+7:0]  pix_wide;
    logic           head_hit, last_byte;
    logic           vs_nxt, de_nxt, hs_nxt, done_nxt, err_nxt;
    logic [PW-1:0]  data_nxt;
    logic [15:0]    fcnt_nxt;

    assign vid_clk = app_rx_clk;

    // A frame length is usable only if non-zero and a whole number of pixels.
    function automatic logic len_ok(input logic [24:0] t);
        return (t != '0) && ((t % 25'(PIX_BYTES)) == '0);
    endfunction

    // Next-state, counter and output decode for the hunt/payload FSM.
    always_comb begin
        state_nxt    = state;
        hd_nxt       = hd;
        tot_nxt      = tot;
        byte_cnt_nxt = byte_cnt;
        lane_nxt     = lane;
        pix_cnt_nxt  = pix_cnt;
        idle_nxt     = idle_cnt;
        pix_nxt      = pix;
        vs_nxt       = 1'b0;
        de_nxt       = 1'b0;
        data_nxt     = '0;
        hs_nxt       = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        fcnt_nxt     = frame_cnt;

        hd_shift  = {hd[23:0], app_rx_data};
        head_hit  = (hd_shift == FRAME_HEAD);
        pix_wide  = {pix, app_rx_data};
        pix_shift = pix_wide[PW-1:0];
        last_byte = (byte_cnt == tot - 25'd1);

        case (state)
            HUNT: begin
                if (app_rx_data_valid) begin
                    if (head_hit) begin
                        hd_nxt = '0;
                        if (len_ok(app_rx_data_total)) begin
                            tot_nxt      = app_rx_data_total;
                            byte_cnt_nxt = '0;
                            lane_nxt     = '0;
                            pix_cnt_nxt  = '0;
                            idle_nxt     = '0;
                            pix_nxt      = '0;
                            vs_nxt       = 1'b1;
                            state_nxt    = PAYLOAD;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else begin
                        hd_nxt = hd_shift;
                    end
                end
            end

            PAYLOAD: begin
                if (app_rx_data_valid) begin
                    idle_nxt = '0;
                    // Frame completion outranks a head match on the same byte.
                    if (RESYNC && head_hit && !last_byte) begin
                        err_nxt      = 1'b1;
                        vs_nxt       = 1'b1;
                        hd_nxt       = '0;
                        byte_cnt_nxt = '0;
                        lane_nxt     = '0;
                        pix_cnt_nxt  = '0;
                        pix_nxt      = '0;
                        if (len_ok(app_rx_data_total)) begin
                            tot_nxt = app_rx_data_total;
                        end else begin
                            state_nxt = HUNT;
                        end
                    end else begin
                        pix_nxt      = pix_shift;
                        byte_cnt_nxt = byte_cnt + 25'd1;
                        if (RESYNC) begin
                            hd_nxt = hd_shift;
                        end
                        if (lane == 2'(PIX_BYTES - 1)) begin
                            lane_nxt = '0;
                            de_nxt   = 1'b1;
                            data_nxt = pix_shift;
                            if (pix_cnt == 16'(LINE_PIX - 1)) begin
                                pix_cnt_nxt = '0;
                                hs_nxt      = 1'b1;
                            end else begin
                                pix_cnt_nxt = pix_cnt + 16'd1;
                            end
                        end else begin
                            lane_nxt = lane + 2'd1;
                        end
                        if (last_byte) begin
                            done_nxt  = 1'b1;
                            fcnt_nxt  = frame_cnt + 16'd1;
                            hd_nxt    = '0;
                            state_nxt = HUNT;
                        end
                    end
                end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    hd_nxt    = '0;
                    pix_nxt   = '0;
                    state_nxt = HUNT;
                end else begin
                    idle_nxt = idle_cnt + TW'(1);
                end
            end

            default: state_nxt = HUNT;
        endcase
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge app_rx_clk) begin
        if (!rstn) begin
            state      <= HUNT;
            hd         <= '0;
            tot        <= '0;
            byte_cnt   <= '0;
            lane       <= '0;
            pix_cnt    <= '0;
            idle_cnt   <= '0;
            pix        <= '0;
            vid_vs     <= 1'b0;
            vid_de     <= 1'b0;
            vid_data   <= '0;
            vid_hs     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            hd         <= hd_nxt;
            tot        <= tot_nxt;
            byte_cnt   <= byte_cnt_nxt;
            lane       <= lane_nxt;
            pix_cnt    <= pix_cnt_nxt;
            idle_cnt   <= idle_nxt;
            pix        <= pix_nxt;
            vid_vs     <= vs_nxt;
            vid_de     <= de_nxt;
            vid_data   <= data_nxt;
            vid_hs     <= hs_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
            frame_cnt  <= fcnt_nxt;
        end
    end

endmodule

// File: tb/tb_udp_rx_vid_unpack.sv
// Testbench for udp_rx_vid_unpack: three instances (2-byte pixels with and
// without resync, 3-byte pixels), directed frames with random payload checked
// against a byte-to-pixel reference model.
module tb_udp_rx_vid_unpack;

    localparam int L = 4;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        hs;
        logic        done;
        int          cyc;
    } pix_t;

    typedef struct {
        int dut;
        int cyc;
    } evt_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vld  [3];
    logic [7:0]  dat  [3];
    logic [24:0] tot  [3];
    logic        vclk [3];
    logic        vs   [3];
    logic        de   [3];
    logic        hs   [3];
    logic        done [3];
    logic        err  [3];
    logic [15:0] fcnt [3];
    logic [31:0] vdat [3];
    logic [15:0] d0;
    logic [23:0] d1;
    logic [15:0] d2;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    pix_t obs[$];
    evt_t vsq[$];
    evt_t errq[$];
    logic [7:0] pb[$];
    int         pe[$];

    always #4 clk = ~clk;

    assign vdat[0] = {16'h0, d0};
    assign vdat[1] = {8'h0, d1};
    assign vdat[2] = {16'h0, d2};

    udp_rx_vid_unpack #(.FRAME_HEAD(32'hF3ED7A93), .PIX_BYTES(2), .LINE_PIX(L), .TIMEOUT(16), .RESYNC(1)) u_p2 (
        .app_rx_clk(clk), .rstn(rstn), .app_rx_data_valid(vld[0]), .app_rx_data(dat[0]),
        .app_rx_data_total(tot[0]), .vid_clk(vclk[0]), .vid_vs(vs[0]), .vid_de(de[0]),
        .vid_data(d0), .vid_hs(hs[0]), .frame_done(done[0]), .frame_err(err[0]), .frame_cnt(fcnt[0]));

    udp_rx_vid_unpack #(.FRAME_HEAD(32'hF3ED7A93), .PIX_BYTES(3), .LINE_PIX(L), .TIMEOUT(16), .RESYNC(1)) u_p3 (
        .app_rx_clk(clk), .rstn(rstn), .app_rx_data_valid(vld[1]), .app_rx_data(dat[1]),
        .app_rx_data_total(tot[1]), .vid_clk(vclk[1]), .vid_vs(vs[1]), .vid_de(de[1]),
        .vid_data(d1), .vid_hs(hs[1]), .frame_done(done[1]), .frame_err(err[1]), .frame_cnt(fcnt[1]));

    udp_rx_vid_unpack #(.FRAME_HEAD(32'hF3ED7A93), .PIX_BYTES(2), .LINE_PIX(L), .TIMEOUT(16), .RESYNC(0)) u_nr (
        .app_rx_clk(clk), .rstn(rstn), .app_rx_data_valid(vld[2]), .app_rx_data(dat[2]),
        .app_rx_data_total(tot[2]), .vid_clk(vclk[2]), .vid_vs(vs[2]), .vid_de(de[2]),
        .vid_data(d2), .vid_hs(hs[2]), .frame_done(done[2]), .frame_err(err[2]), .frame_cnt(fcnt[2]));

    // Edge counter: an output registered at edge n is observed at the following negedge with cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        checks++;
        assert (o === x) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
        end
    endtask

    // Monitor: record pixels and pulses, and check per-cycle output invariants.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("vid_clk%0d", i), 32'(vclk[i]), 32'(clk));
                if (de[i] !== 1'b1) begin
                    chk($sformatf("zero_data%0d", i), vdat[i], 32'h0);
                    chk($sformatf("hs_done_wo_de%0d", i), 32'(hs[i] | done[i]), 32'h0);
                end else begin
                    obs.push_back('{i, vdat[i], hs[i], done[i], cyc});
                end
                if (vs[i] === 1'b1) vsq.push_back('{i, cyc});
                if (err[i] === 1'b1) errq.push_back('{i, cyc});
            end
        end
    end

    function automatic logic [7:0] rb();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hF3) b = 8'h5A;
        return b;
    endfunction

    task automatic put(input int u, input logic [7:0] b, output int e);
        @(negedge clk);
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        vld[u] = 1'b1;
        dat[u] = b;
        e = cyc + 1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        end
    endtask

    task automatic head(input int u, input int total, output int e);
        int x;
        tot[u] = 25'(total);
        put(u, 8'hF3, x);
        put(u, 8'hED, x);
        put(u, 8'h7A, x);
        put(u, 8'h93, e);
    endtask

    task automatic pay_byte(input int u, input logic [7:0] b);
        int e;
        put(u, b, e);
        pb.push_back(b);
        pe.push_back(e);
    endtask

    task automatic payload(input int u, input int n, input bit toggle, input bit seq);
        for (int k = 0; k < n; k++) begin
            pay_byte(u, seq ? 8'(k) : rb());
            if (toggle) gap(1);
        end
    endtask

    task automatic clear_all();
        obs.delete();
        vsq.delete();
        errq.delete();
        pb.delete();
        pe.delete();
    endtask

    function automatic int n_pix(input int u);
        int n = 0;
        foreach (obs[i]) if (obs[i].dut == u) n++;
        return n;
    endfunction

    // Reference: pixel k of a frame is bytes k*P..k*P+P-1 MSB-first, seen one cycle
    // after its last byte; every L-th pixel ends a line; the final one ends the frame.
    task automatic check_pixels(input string tag, input int u, input int p, input int boff,
                                input int nbytes, input int poff, input bit fin);
        pix_t        got[$];
        int          npix;
        logic [31:0] d;
        foreach (obs[i]) if (obs[i].dut == u) got.push_back(obs[i]);
        npix = nbytes / p;
        for (int k = 0; k < npix && poff + k < got.size(); k++) begin
            d = '0;
            for (int j = 0; j < p; j++) d = (d << 8) | 32'(pb[boff + k * p + j]);
            chk($sformatf("%s_data%0d", tag, k), got[poff + k].data, d);
            chk($sformatf("%s_hs%0d", tag, k), 32'(got[poff + k].hs), 32'((k + 1) % L == 0));
            chk($sformatf("%s_done%0d", tag, k), 32'(got[poff + k].done), 32'(fin && k == npix - 1));
            chk($sformatf("%s_cyc%0d", tag, k), got[poff + k].cyc, pe[boff + k * p + p - 1]);
        end
    endtask

    task automatic check_evt(input string tag, input int u, input bit is_err,
                             input int n, input int c0, input int c1);
        int got[$];
        if (is_err) begin
            foreach (errq[i]) if (errq[i].dut == u) got.push_back(errq[i].cyc);
        end else begin
            foreach (vsq[i]) if (vsq[i].dut == u) got.push_back(vsq[i].cyc);
        end
        chk({tag, "_count"}, got.size(), n);
        if (n > 0 && got.size() > 0) chk({tag, "_cyc0"}, got[0], c0);
        if (n > 1 && got.size() > 1) chk({tag, "_cyc1"}, got[1], c1);
    endtask

    task automatic check_idle(input string tag, input int u);
        chk({tag, "_vs"}, 32'(vs[u]), 32'h0);
        chk({tag, "_de"}, 32'(de[u]), 32'h0);
        chk({tag, "_hs"}, 32'(hs[u]), 32'h0);
        chk({tag, "_done"}, 32'(done[u]), 32'h0);
        chk({tag, "_err"}, 32'(err[u]), 32'h0);
        chk({tag, "_data"}, vdat[u], 32'h0);
        chk({tag, "_fcnt"}, 32'(fcnt[u]), 32'h0);
    endtask

    initial begin
        int he, he2, em, x;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld[i] = 1'b0;
            dat[i] = 8'h0;
            tot[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle($sformatf("reset%0d", i), i);
        rstn = 1'b1;
        clear_all();

        // Timeout: 5 of 16 bytes then silence; error on the 16th idle edge.
        head(0, 16, he);
        payload(0, 5, 1'b0, 1'b0);
        gap(20);
        check_evt("to_vs", 0, 1'b0, 1, he, 0);
        check_evt("to_err", 0, 1'b1, 1, pe[4] + 16, 0);
        chk("to_npix", n_pix(0), 2);
        check_pixels("to", 0, 2, 0, 5, 0, 1'b0);
        chk("to_fcnt", 32'(fcnt[0]), 32'd1 - 32'd1);
        clear_all();

        // Continuous 0x00..0x0F frame, then a back-to-back head with toggling valid.
        head(0, 16, he);
        payload(0, 16, 1'b0, 1'b1);
        head(0, 24, he2);
        payload(0, 24, 1'b1, 1'b0);
        gap(3);
        check_evt("b_vs", 0, 1'b0, 2, he, he2);
        check_evt("b_err", 0, 1'b1, 0, 0, 0);
        chk("b_npix", n_pix(0), 20);
        check_pixels("b1", 0, 2, 0, 16, 0, 1'b1);
        check_pixels("b2", 0, 2, 16, 24, 8, 1'b1);
        chk("b_fcnt", 32'(fcnt[0]), 32'd2);
        clear_all();

        // 3-byte pixels: bad length rejected in HUNT, then a good 6-byte frame.
        head(1, 7, he);
        for (int k = 0; k < 3; k++) put(1, rb(), x);
        gap(2);
        head(1, 6, he2);
        payload(1, 6, 1'b0, 1'b0);
        gap(3);
        check_evt("c_err", 1, 1'b1, 1, he, 0);
        check_evt("c_vs", 1, 1'b0, 1, he2, 0);
        chk("c_npix", n_pix(1), 2);
        check_pixels("c", 1, 3, 0, 6, 0, 1'b1);
        chk("c_fcnt", 32'(fcnt[1]), 32'd1);
        clear_all();

        // Resync: head injected at payload byte 9, new frame of 8 bytes follows.
        head(0, 16, he);
        payload(0, 9, 1'b0, 1'b0);
        tot[0] = 25'd8;
        pay_byte(0, 8'hF3);
        pay_byte(0, 8'hED);
        pay_byte(0, 8'h7A);
        pay_byte(0, 8'h93);
        em = pe[12];
        payload(0, 8, 1'b0, 1'b0);
        gap(3);
        check_evt("d_vs", 0, 1'b0, 2, he, em);
        check_evt("d_err", 0, 1'b1, 1, em, 0);
        chk("d_npix", n_pix(0), 10);
        check_pixels("d1", 0, 2, 0, 12, 0, 1'b0);
        check_pixels("d2", 0, 2, 13, 8, 6, 1'b1);
        chk("d_fcnt", 32'(fcnt[0]), 32'd3);
        clear_all();

        // Same pattern without resync: head bytes are ordinary payload.
        head(2, 16, he);
        payload(2, 9, 1'b0, 1'b0);
        pay_byte(2, 8'hF3);
        pay_byte(2, 8'hED);
        pay_byte(2, 8'h7A);
        pay_byte(2, 8'h93);
        payload(2, 3, 1'b0, 1'b0);
        gap(3);
        check_evt("e_vs", 2, 1'b0, 1, he, 0);
        check_evt("e_err", 2, 1'b1, 0, 0, 0);
        chk("e_npix", n_pix(2), 8);
        check_pixels("e", 2, 2, 0, 16, 0, 1'b1);
        chk("e_fcnt", 32'(fcnt[2]), 32'd1);
        clear_all();

        // One-cycle reset mid-payload, then a clean frame.
        head(0, 16, he);
        payload(0, 7, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) vld[i] = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle($sformatf("mid_rst%0d", i), i);
        rstn = 1'b1;
        clear_all();
        head(0, 16, he);
        payload(0, 16, 1'b0, 1'b0);
        gap(3);
        check_evt("f_vs", 0, 1'b0, 1, he, 0);
        check_evt("f_err", 0, 1'b1, 0, 0, 0);
        chk("f_npix", n_pix(0), 8);
        check_pixels("f", 0, 2, 0, 16, 0, 1'b1);
        chk("f_fcnt", 32'(fcnt[0]), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
